// File: rtl/pc_predict_pkg.sv
// Shared types, counter encodings and the BHT index helper for the
// fetch-stage next-PC generator.
package pc_predict_pkg;

  // Fetch-side sequencing: normal fetch, or parked on a JALR until EX
  // supplies the register-based target.
  typedef enum logic [0:0] {
    RUN       = 1'b0,
    JALR_WAIT = 1'b1
  } pc_state_e;

  // 2-bit saturating counter encodings; bit 1 is the taken prediction.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // BHT index of a PC. With compressed instructions enabled, halfword
  // granularity matters, so the index starts at bit 1; otherwise at bit 2.
  function automatic int unsigned idx(input logic [63:0] pc,
                                      input bit c_ext,
                                      input int unsigned idx_w);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = c_ext ? (pc >> 1) : (pc >> 2);
    mask    = (64'd1 << idx_w) - 64'd1;
    return 32'(shifted & mask);
  endfunction

endpackage

// File: rtl/pc_predict_unit_bht.sv
// Branch history table: an array of 2-bit saturating counters with one
// combinational read port and one synchronous update port.
module pc_bht
  import pc_predict_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = WNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr [ENTRIES];

  // Read is purely combinational, so a same-cycle write is not visible yet.
  assign rd_ctr = ctr[rd_idx];

  // Reset every counter, otherwise saturate toward the resolved outcome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (wr_en) begin
      if (wr_taken) begin
        if (ctr[wr_idx] != ST) ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
      end else begin
        if (ctr[wr_idx] != SNT) ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Next-PC generator for an RV32IC fetch stage: owns the PC, predicts
// conditional branches from a BHT, parks on JALR until its target is known,
// and redirects on EX-stage mispredictions.
//
// Handshake: jalr_valid_i is a qualifier for jalr_target_i and is only
// consumed while parked in JALR_WAIT and not stalled; there is no ready
// back-pressure, EX is expected to hold the target valid until consumed.
module pc_predict_unit
  import pc_predict_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      BHT_ENTRIES = 16,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter logic [1:0]       CTR_INIT    = 2'b01,
  parameter bit               C_EXT       = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            if_branch_i,
  input  logic            if_jal_i,
  input  logic            if_jalr_i,
  input  logic            compressed_i,
  input  logic [XLEN-1:0] imm_ext_i,
  input  logic            jalr_valid_i,
  input  logic [XLEN-1:0] jalr_target_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_pred_taken_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic [XLEN-1:0] ex_fallthru_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic [XLEN-1:0] pc_imm_o,
  output logic            pred_taken_o,
  output logic            flush_o,
  output pc_state_e       state_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0]  pc_q;
  pc_state_e        state_q;
  logic             flush_q;
  logic             mispredict;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       rd_ctr;
  logic [XLEN-1:0]  jalr_pc;

  assign pc_o    = pc_q;
  assign flush_o = flush_q;
  assign state_o = state_q;

  // Sequential and relative targets wrap modulo 2^XLEN.
  assign pc_plus_o = pc_q + (compressed_i ? XLEN'(2) : XLEN'(4));
  assign pc_imm_o  = pc_q + imm_ext_i;

  // JALR targets have bit 0 cleared as the ISA requires.
  assign jalr_pc = jalr_target_i & {{(XLEN-1){1'b1}}, 1'b0};

  assign mispredict = ex_valid_i & (ex_taken_i != ex_pred_taken_i);

  assign rd_idx = IDX_W'(idx(64'(pc_q), C_EXT, IDX_W));
  assign wr_idx = IDX_W'(idx(64'(ex_pc_i), C_EXT, IDX_W));

  // While parked on a JALR the fetch-side decode is meaningless.
  assign pred_taken_o = (state_q == RUN) & if_branch_i & rd_ctr[1];

  pc_bht #(
    .ENTRIES  (BHT_ENTRIES),
    .IDX_W    (IDX_W),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (rd_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (ex_valid_i),
    .wr_idx   (wr_idx),
    .wr_taken (ex_taken_i)
  );

  // PC / state / flush update: mispredict beats stall beats everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      flush_q <= 1'b0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) begin
        pc_q    <= ex_taken_i ? ex_target_i : ex_fallthru_i;
        state_q <= RUN;
      end else if (!stall_i) begin
        case (state_q)
          RUN: begin
            if (if_jalr_i) begin
              state_q <= JALR_WAIT;
            end else if (if_jal_i | pred_taken_o) begin
              pc_q <= pc_imm_o;
            end else begin
              pc_q <= pc_plus_o;
            end
          end
          JALR_WAIT: begin
            if (jalr_valid_i) begin
              pc_q    <= jalr_pc;
              state_q <= RUN;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

endmodule
